// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// iter_shifter : multi-cycle SRL/SRA/SLL/ROR shifter, up to STEP bits per clock
// Optional ROR wrap path: ITER_SHIFTER_ROTATE_EN (undefined -> op 11 acts as SRL)
// Rev 1.0
// ============================================================================
module iter_shifter #(
  parameter int WIDTH = 64,
  parameter int STEP  = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One extra bit so STEP == WIDTH is representable.
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [AW:0]      rem_ext;
  logic [AW:0]      step_amt;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    rem_ext  = {1'b0, rem_q};
    step_amt = (rem_ext >= STEP_W) ? STEP_W : rem_ext;
    case (op_q)
      2'b01:   shifted = $signed(data_q) >>> step_amt;
      2'b10:   shifted = data_q << step_amt;
`ifdef ITER_SHIFTER_ROTATE_EN
      // step_amt is 1..WIDTH-1 while shifting, so both halves are in range.
      2'b11:   shifted = (data_q >> step_amt) | (data_q << (WIDTH - int'(step_amt)));
`endif
      default: shifted = data_q >> step_amt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          op_d    = in_op;
          rem_d   = in_amt;
          state_d = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - step_amt[AW-1:0];
        if (rem_ext == step_amt) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered from the next state: no in->out paths.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      op_q        <= 2'b00;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

endmodule
`default_nettype wire
